// File: rtl/mac_feeder.sv
`default_nettype none
// ============================================================================
// Module      : mac_feeder
// Description : Transmit-side sequencer for the mac block. Holds a local
//               coefficient store and, per start, pushes taylor_length+1
//               coefficients into the coefficient FIFO followed by
//               taylor_length+1 upstream signal words into the signal FIFO.
//               Optional feature macro: MAC_FEEDER_LAST_CHECK_EN (flags a
//               mismatch between s_last_i and the final signal word on err_o).
// Revision    : 1.0 - initial release
// ============================================================================
module mac_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_LINES = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_we_i,
  input  logic [ADDR_LINES-1:0] cfg_addr_i,
  input  logic [DATA_WIDTH-1:0] cfg_data_i,
  input  logic [ADDR_LINES-1:0] taylor_length_i,
  input  logic                  start_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_last_i,
  output logic [DATA_WIDTH-1:0] coeff_o,
  output logic                  wr_en_coeff_o,
  output logic                  last_coeff_o,
  input  logic                  full_coeff_i,
  output logic [DATA_WIDTH-1:0] signal_o,
  output logic                  wr_en_signal_o,
  output logic                  last_signal_o,
  input  logic                  full_signal_i,
  output logic [ADDR_LINES-1:0] taylor_length_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int                    c_depth   = 1 << ADDR_LINES;
  localparam logic [ADDR_LINES-1:0] c_idx_one = ADDR_LINES'(1);
  localparam logic [ADDR_LINES-1:0] c_idx_zero = '0;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_LOAD_COEFF  = 2'd1,
    ST_LOAD_SIGNAL = 2'd2,
    ST_DONE        = 2'd3
  } state_t;

  state_t                r_state;
  logic [ADDR_LINES-1:0] r_index;
  logic [ADDR_LINES-1:0] r_tl;
  logic                  r_busy;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_store [0:c_depth-1];

  logic w_in_coeff;
  logic w_in_signal;
  logic w_idx_last;
  logic w_wr_coeff;
  logic w_wr_signal;
  logic w_cfg_ok;

  // Write strobes are gated by rst_i so an abort stops FIFO writes in the
  // very cycle reset is raised, not one cycle later.
  assign w_in_coeff  = (r_state == ST_LOAD_COEFF)  && !rst_i;
  assign w_in_signal = (r_state == ST_LOAD_SIGNAL) && !rst_i;
  assign w_idx_last  = (r_index == r_tl);
  assign w_wr_coeff  = w_in_coeff && !full_coeff_i;
  assign w_wr_signal = w_in_signal && s_valid_i && !full_signal_i;
  assign w_cfg_ok    = cfg_we_i && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // Data outputs are zeroed outside their phase so idle/reset outputs read 0.
  assign coeff_o         = w_in_coeff ? r_store[r_index] : '0;
  assign wr_en_coeff_o   = w_wr_coeff;
  assign last_coeff_o    = w_wr_coeff && w_idx_last;
  assign signal_o        = w_in_signal ? s_data_i : '0;
  assign s_ready_o       = w_in_signal && !full_signal_i;
  assign wr_en_signal_o  = w_wr_signal;
  assign last_signal_o   = w_wr_signal && w_idx_last;
  assign taylor_length_o = r_tl;
  assign busy_o          = r_busy;
  assign done_o          = r_done;

`ifdef MAC_FEEDER_LAST_CHECK_EN
  logic r_err;
  assign err_o = r_err;
`else
  logic w_unused_last;
  assign w_unused_last = s_last_i;
  assign err_o         = 1'b0;
`endif

  // Coefficient store: not reset, writable only while no load is in progress
  always_ff @(posedge clk_i) begin
    if (w_cfg_ok) begin
      r_store[cfg_addr_i] <= cfg_data_i;
    end
  end

  // Sequencer: index counts words of the current phase, tl compare ends it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_index <= c_idx_zero;
      r_tl    <= c_idx_zero;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef MAC_FEEDER_LAST_CHECK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_tl    <= taylor_length_i;
            r_index <= c_idx_zero;
            r_busy  <= 1'b1;
            r_state <= ST_LOAD_COEFF;
`ifdef MAC_FEEDER_LAST_CHECK_EN
            r_err   <= 1'b0;
`endif
          end
        end
        ST_LOAD_COEFF: begin
          if (w_wr_coeff) begin
            if (w_idx_last) begin
              r_index <= c_idx_zero;
              r_state <= ST_LOAD_SIGNAL;
            end else begin
              r_index <= r_index + c_idx_one;
            end
          end
        end
        ST_LOAD_SIGNAL: begin
          if (w_wr_signal) begin
`ifdef MAC_FEEDER_LAST_CHECK_EN
            if (s_last_i != w_idx_last) begin
              r_err <= 1'b1;
            end
`endif
            if (w_idx_last) begin
              r_index <= c_idx_zero;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_index <= r_index + c_idx_one;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mac_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_feeder
// Description : Self-checking bench for mac_feeder. A queue-based model holds
//               the words each phase must emit; one compare process checks
//               the DUT against it every cycle, and directed tests pin exact
//               cycle timing with hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_feeder;

  localparam int DW    = 32;
  localparam int AL    = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          cfg_we_i = 1'b0;
  logic [AL-1:0] cfg_addr_i = '0;
  logic [DW-1:0] cfg_data_i = '0;
  logic [AL-1:0] taylor_length_i = '0;
  logic          start_i = 1'b0;
  logic          s_valid_i;
  logic          s_ready_o;
  logic [DW-1:0] s_data_i;
  logic          s_last_i;
  logic [DW-1:0] coeff_o;
  logic          wr_en_coeff_o, last_coeff_o;
  logic          full_coeff_i = 1'b0;
  logic [DW-1:0] signal_o;
  logic          wr_en_signal_o, last_signal_o;
  logic          full_signal_i = 1'b0;
  logic [AL-1:0] taylor_length_o;
  logic          busy_o, done_o, err_o;

  always #5 clk = ~clk;

  mac_feeder #(.DATA_WIDTH(DW), .ADDR_LINES(AL)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
    .taylor_length_i(taylor_length_i), .start_i(start_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i), .s_last_i(s_last_i),
    .coeff_o(coeff_o), .wr_en_coeff_o(wr_en_coeff_o), .last_coeff_o(last_coeff_o),
    .full_coeff_i(full_coeff_i),
    .signal_o(signal_o), .wr_en_signal_o(wr_en_signal_o), .last_signal_o(last_signal_o),
    .full_signal_i(full_signal_i),
    .taylor_length_o(taylor_length_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  int            n_pass = 0;
  int            n_total = 0;
  word_t         exp_c[$];
  word_t         exp_s[$];
  word_t         cmp_e;
  logic [DW-1:0] mdl_store [DEPTH];
  logic [AL-1:0] mdl_tl = '0;
  logic          mdl_err = 1'b0;
  logic          exp_done = 1'b0;
  logic          done_now, err_now;
  int unsigned   cyc = 0;
  int unsigned   sig_cnt = 0;
  int unsigned   sig_base = 0;
  int unsigned   sig_tl = 0;
  int            n_cw = 0;
  int            n_sw = 0;
  logic          valid_en = 1'b0;
  logic          valid_alt = 1'b0;
  logic          last_bad = 1'b0;

  // Upstream source: an incrementing word stream, consumed on handshake
  assign s_valid_i = valid_en && (valid_alt ? cyc[0] : 1'b1);
  assign s_data_i  = 32'hA000_0000 + sig_cnt;
  assign s_last_i  = ((sig_cnt - sig_base) == (last_bad ? 32'd1 : sig_tl));

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (s_valid_i && s_ready_o) sig_cnt <= sig_cnt + 1;
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the queue model
  always @(negedge clk) begin
    if (rst_i) begin
      exp_done = 1'b0;
    end else begin
      check("busy", busy_o, (exp_c.size() + exp_s.size()) != 0);
      check("done", done_o, exp_done);
      check("err", err_o, mdl_err);
      check("tl_out", taylor_length_o, mdl_tl);
      done_now = 1'b0;
      err_now  = mdl_err;
      if (exp_c.size() != 0) begin
        check("coeff_wr_en", wr_en_coeff_o, !full_coeff_i);
        check("sig_wr_en_in_coeff", wr_en_signal_o, 1'b0);
        check("s_ready_in_coeff", s_ready_o, 1'b0);
        if (wr_en_coeff_o) begin
          cmp_e = exp_c.pop_front();
          check("coeff_data", coeff_o, cmp_e.data);
          check("coeff_last", last_coeff_o, cmp_e.last);
          n_cw++;
        end else begin
          check("coeff_stall_hold", coeff_o, exp_c[0].data);
          check("coeff_last_stall", last_coeff_o, 1'b0);
        end
      end else if (exp_s.size() != 0) begin
        check("s_ready", s_ready_o, !full_signal_i);
        check("sig_wr_en", wr_en_signal_o, s_valid_i && !full_signal_i);
        check("coeff_wr_en_in_sig", wr_en_coeff_o, 1'b0);
        if (wr_en_signal_o) begin
          cmp_e = exp_s.pop_front();
          check("sig_data", signal_o, cmp_e.data);
          check("sig_last", last_signal_o, cmp_e.last);
          n_sw++;
          done_now = cmp_e.last;
`ifdef MAC_FEEDER_LAST_CHECK_EN
          if (s_last_i != cmp_e.last) err_now = 1'b1;
`endif
        end else begin
          check("sig_last_stall", last_signal_o, 1'b0);
        end
      end else begin
        check("idle_wr_en_coeff", wr_en_coeff_o, 1'b0);
        check("idle_wr_en_sig", wr_en_signal_o, 1'b0);
        check("idle_s_ready", s_ready_o, 1'b0);
        check("idle_last", {last_coeff_o, last_signal_o}, 0);
      end
      exp_done = done_now;
      mdl_err  = err_now;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int a, input logic [DW-1:0] d);
    cfg_we_i   = 1'b1;
    cfg_addr_i = a[AL-1:0];
    cfg_data_i = d;
    tick();
    cfg_we_i   = 1'b0;
    mdl_store[a] = d;
  endtask

  // Assert start for one cycle (DUT assumed idle) and load the model queues
  task automatic start_txn(input int tl);
    taylor_length_i = tl[AL-1:0];
    start_i = 1'b1;
    tick();
    start_i  = 1'b0;
    mdl_tl   = tl[AL-1:0];
    mdl_err  = 1'b0;
    sig_base = sig_cnt;
    sig_tl   = tl;
    n_cw = 0;
    n_sw = 0;
    for (int k = 0; k <= tl; k++) begin
      exp_c.push_back('{data: mdl_store[k], last: (k == tl)});
      exp_s.push_back('{data: 32'hA000_0000 + sig_base + k, last: (k == tl)});
    end
  endtask

  task automatic wait_done(input int budget, input string name);
    int i = 0;
    while (!done_o && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, done_o, 1'b1);
    check({name, "_drained"}, exp_c.size() + exp_s.size(), 0);
    tick();
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_flags"}, {wr_en_coeff_o, last_coeff_o, wr_en_signal_o, last_signal_o,
                             s_ready_o, busy_o, done_o, err_o}, 0);
    check({name, "_tl"}, taylor_length_o, 0);
    check({name, "_coeff"}, coeff_o, 0);
    check({name, "_signal"}, signal_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    // Reset state
    rst_i = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check_all_zero("reset");
    tick();
    rst_i = 1'b0;
    for (int k = 0; k < DEPTH; k++) cfg_write(k, k + 1);
    valid_en = 1'b1;

    // Test 1: nominal timing, coeffs 1..4, no backpressure
    start_txn(3);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check("t1_wr_coeff", wr_en_coeff_o, (k >= 1 && k <= 4));
      if (k <= 4) check("t1_coeff_val", coeff_o, k);
      check("t1_last_coeff", last_coeff_o, (k == 4));
      check("t1_wr_sig", wr_en_signal_o, (k >= 5 && k <= 8));
      if (k == 5) check("t1_sig_first", signal_o, 32'hA000_0000 + sig_base);
      check("t1_last_sig", last_signal_o, (k == 8));
      check("t1_done", done_o, (k == 9));
    end
    tick();

    // Test 2: coefficient FIFO full for 3 cycles after the 2nd write
    start_txn(3);
    cnt = 0;
    for (int i = 0; i < 20 && cnt < 2; i++) begin
      @(negedge clk);
      if (wr_en_coeff_o) cnt++;
    end
    check("t2_two_writes", cnt, 2);
    tick();
    full_coeff_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_hold_val", coeff_o, 3);
      check("t2_hold_wr", wr_en_coeff_o, 1'b0);
      tick();
    end
    full_coeff_i = 1'b0;
    wait_done(40, "t2_done");
    check("t2_coeff_total", n_cw, 4);
    check("t2_sig_total", n_sw, 4);

    // Test 3: full-depth transaction, gappy upstream valid
    valid_alt = 1'b1;
    start_txn(31);
    wait_done(300, "t3_done");
    check("t3_coeff_total", n_cw, 32);
    check("t3_sig_total", n_sw, 32);
    valid_alt = 1'b0;

    // Test 4: cfg write while loading and start during LOAD_SIGNAL are ignored
    full_signal_i = 1'b1;
    start_txn(3);
    cfg_we_i = 1'b1; cfg_addr_i = '0; cfg_data_i = 32'hDEAD_BEEF;
    tick();
    cfg_we_i = 1'b0;
    repeat (4) tick();
    check("t4_in_signal", busy_o, 1'b1);
    taylor_length_i = 5'd7;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    full_signal_i = 1'b0;
    wait_done(40, "t4_done");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_stays_idle", busy_o, 1'b0);
      check("t4_tl_kept", taylor_length_o, 3);
    end
    tick();
    start_txn(3);
    @(negedge clk);
    check("t4_store_kept", coeff_o, 1);
    wait_done(40, "t4b_done");

    // Test 5: reset mid LOAD_COEFF aborts, fresh start reloads from coeff 0
    start_txn(3);
    @(negedge clk);
    tick();
    rst_i = 1'b1;
    exp_c.delete();
    exp_s.delete();
    mdl_tl = '0;
    mdl_err = 1'b0;
    @(negedge clk);
    check("t5_abort_wr", wr_en_coeff_o, 1'b0);
    tick();
    @(negedge clk);
    check_all_zero("t5_after_rst");
    tick();
    rst_i = 1'b0;
    tick();
    start_txn(3);
    @(negedge clk);
    check("t5_restart_val", coeff_o, 1);
    check("t5_restart_wr", wr_en_coeff_o, 1'b1);
    wait_done(40, "t5_done");

    // Test 6: s_last_i on the 2nd signal word
    last_bad = 1'b1;
    start_txn(3);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 6) check("t6_err_before", err_o, 1'b0);
`ifdef MAC_FEEDER_LAST_CHECK_EN
      if (k == 7) check("t6_err_set", err_o, 1'b1);
`else
      if (k == 7) check("t6_err_tied", err_o, 1'b0);
`endif
    end
    wait_done(20, "t6_done");
    check("t6_sig_total", n_sw, 4);
    last_bad = 1'b0;
    start_txn(1);
    @(negedge clk);
    check("t6_err_cleared", err_o, 1'b0);
    wait_done(20, "t6b_done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mac_feeder.md
# mac_feeder

Transmit-side sequencer that loads one Taylor-series evaluation into the `mac` block's input FIFOs. It stores the coefficient table locally and, on `start_i`, pushes taylor_length+1 coefficients into the coefficient FIFO and then taylor_length+1 signal words from an upstream valid/ready stream into the signal FIFO. It marks the final word of each phase with `last_*` and respects the FIFO `full` flags. It sits directly upstream of `mac`, driving its `wr_en_*`, `last_*`, `coeff_fifo`, `signal_fifo` and `taylor_length` inputs.

## Interface
- DATA_WIDTH, 32, width of coefficient and signal words.
- ADDR_LINES, 5, coefficient store address width; store depth is 2^ADDR_LINES.

- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- cfg_we_i  in  1  coefficient store write strobe.
- cfg_addr_i  in  ADDR_LINES  coefficient store write address.
- cfg_data_i  in  DATA_WIDTH  coefficient store write data.
- taylor_length_i  in  ADDR_LINES  term count minus 1; sampled on accepted start.
- start_i  in  1  begin a transaction; sampled only in IDLE.
- s_valid_i / s_ready_o  in/out  1  upstream signal handshake.
- s_data_i  in  DATA_WIDTH  upstream signal word.
- s_last_i  in  1  upstream end-of-vector marker.
- coeff_o  out  DATA_WIDTH  to `mac` coeff_fifo.
- wr_en_coeff_o, last_coeff_o  out  1  to `mac` wr_en_coeff / last_coeff.
- full_coeff_i  in  1  from `mac` full_adder.
- signal_o  out  DATA_WIDTH  to `mac` signal_fifo.
- wr_en_signal_o, last_signal_o  out  1  to `mac` wr_en_signal / last_signal.
- full_signal_i  in  1  from `mac` full_mul.
- taylor_length_o  out  ADDR_LINES  latched length to `mac` taylor_length.
- busy_o, done_o, err_o  out  1  status.

## Operation
- States: IDLE, LOAD_COEFF, LOAD_SIGNAL, DONE.
- IDLE: when start_i=1, latch taylor_length_i into tl_q, clear index and err_o, and go to LOAD_COEFF.
- LOAD_COEFF:
  - coeff_o = store[index] (combinational read).
  - wr_en_coeff_o = ~full_coeff_i.
  - On each write, index increments.
  - last_coeff_o = wr_en_coeff_o & (index == tl_q).
  - That final write clears index and moves to LOAD_SIGNAL.
- LOAD_SIGNAL:
  - s_ready_o = ~full_signal_i.
  - wr_en_signal_o = s_valid_i & ~full_signal_i.
  - signal_o = s_data_i.
  - last_signal_o = wr_en_signal_o & (index == tl_q).
  - The final write moves to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- busy_o = 1 in LOAD_COEFF and LOAD_SIGNAL.
- Counting: N = tl_q+1 words per phase, 1..2^ADDR_LINES. index is ADDR_LINES wide and is compared to tl_q, so there is no +1 overflow at tl_q = all-ones.
- Store writes: cfg_we_i writes in IDLE and DONE only. Writes while busy_o=1 are dropped.
- start_i outside IDLE is ignored.
- taylor_length_o = tl_q at all times.
- Outside the LOAD states: all wr_en/last/s_ready outputs are 0, and coeff_o and signal_o are don't-care.

## Timing
- Reset: state IDLE, index 0, tl_q 0.
- Output values under reset: all outputs 0, including busy_o, done_o, err_o, s_ready_o and taylor_length_o.
- The coefficient store is not cleared by reset.
- Reset mid-transaction aborts immediately. No further writes occur; partially loaded `mac` FIFOs are the `mac`'s concern.
- Latency:
  - start_i → first coefficient write: 1 cycle, if not full.
  - Zero bubbles between phases: the final coefficient write is followed by the first signal write in the next cycle.
  - Signal path is combinational pass-through (0 cycles).
- Backpressure:
  - full_* gates the write in the same cycle.
  - A full cycle stalls index and state; the stalled word is re-presented unchanged.
- Minimum transaction: 2N+2 cycles, from start acceptance to IDLE.

## Configuration
- MAC_FEEDER_LAST_CHECK_EN defined: a signal write where s_last_i != (index == tl_q) sets err_o.
  - err_o is sticky until the next accepted start.
  - The transaction still completes after exactly N words.
- MAC_FEEDER_LAST_CHECK_EN undefined: s_last_i is ignored and err_o is tied 0.

## Test plan
- Store coeffs 1..4, taylor_length=3, start, fulls=0, s_valid held high:
  - wr_en_coeff on cycles 1–4 with coeff_o 1,2,3,4 and last_coeff on the 4th.
  - wr_en_signal on cycles 5–8 with last_signal on the 8th.
  - done_o on cycle 9.
- Same as above, with full_coeff_i=1 for 3 cycles after the 2nd coefficient write:
  - coeff_o holds 3 with no writes during those cycles.
  - Totals are 4 coeff and 4 signal writes.
- taylor_length=31, ADDR_LINES=5 → exactly 32 writes per phase, last on index 31, no wrap.
- start_i pulsed during LOAD_SIGNAL and a cfg write during LOAD_COEFF → both ignored, and the store is unchanged after done.
- rst_i asserted mid LOAD_COEFF → next cycle all outputs 0 and IDLE; a fresh start reloads from coefficient 0.
- With MAC_FEEDER_LAST_CHECK_EN, taylor_length=3 and s_last_i on the 2nd signal word → err_o=1 from the next cycle, 4 signal writes still issued, err_o cleared on the next start.
